// File: rtl/ru_pkg.sv
// Shared types for the register-unit write arbiter: register index, write request
// and write-source tag.
package ru_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;
    localparam int RU_DATA_W = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t               rd;
        logic [RU_DATA_W-1:0]   data;
    } wr_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_LU   = 2'd2
    } wr_src_e;

endpackage

// File: rtl/ru_wr_arbiter_if.sv
// Bundle of writeback, long-latency, scoreboard and register-unit signals.
// master = pipeline / long-latency side, slave = the arbiter.
interface ru_wr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
);
    logic                 wbWr;
    ru_pkg::reg_idx_t     wbRd;
    logic [DATA_W-1:0]    wbData;
    logic                 wbStall;

    logic                 luValid;
    logic                 luReady;
    ru_pkg::reg_idx_t     luRd;
    logic [DATA_W-1:0]    luData;

    logic                 allocValid;
    ru_pkg::reg_idx_t     allocRd;
    ru_pkg::reg_idx_t     rs1;
    ru_pkg::reg_idx_t     rs2;
    logic                 hazRs1;
    logic                 hazRs2;
    logic [NREG-1:0]      pendMask;
    logic                 allocErr;

    logic                 ruWr;
    ru_pkg::reg_idx_t     ruRd;
    logic [DATA_W-1:0]    ruData;

    modport master (
        output wbWr, wbRd, wbData, luValid, luRd, luData, allocValid, allocRd, rs1, rs2,
        input  wbStall, luReady, hazRs1, hazRs2, pendMask, allocErr, ruWr, ruRd, ruData
    );

    modport slave (
        input  wbWr, wbRd, wbData, luValid, luRd, luData, allocValid, allocRd, rs1, rs2,
        output wbStall, luReady, hazRs1, hazRs2, pendMask, allocErr, ruWr, ruRd, ruData
    );

endinterface

// File: rtl/ru_wr_fifo.sv
// Small synchronous FIFO with an exact occupancy count; push and pop may coincide.
module ru_wr_fifo #(
    parameter type entry_t = ru_pkg::wr_req_t,
    parameter int  DEPTH   = 2,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           din,
    input  logic             pop,
    output entry_t           dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ru_wr_arbiter.sv
// Single register-unit write port shared by pipeline writeback (priority) and a
// queued long-latency unit, with anti-starvation and a RAW pending scoreboard.
module ru_wr_arbiter
    import ru_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NREG         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ru_wr_arbiter_if.slave   bus
);

    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        reg_idx_t          rd;
        logic [DATA_W-1:0] data;
    } lu_req_t;

    lu_req_t           head;
    lu_req_t           fifo_din;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              push;
    logic              pop;

    wr_src_e           grant;
    logic              wb_req;
    logic              wb_stall;
    logic [SC_W-1:0]   starve_cnt;

    logic              ru_wr;
    reg_idx_t          ru_rd;
    logic [DATA_W-1:0] ru_data;
    wr_src_e           out_src;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_set;
    logic [NREG-1:0]   pend_clr;
    logic              alloc_err;

    // Zero-destination results complete the handshake but are dropped here.
    assign fifo_din = '{rd: bus.luRd, data: bus.luData};
    assign push     = bus.luValid && !fifo_full && (bus.luRd != '0);

    ru_wr_fifo #(
        .entry_t (lu_req_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        wb_req = bus.wbWr && (bus.wbRd != '0) && !wb_stall;
        grant  = SRC_NONE;
        if (wb_req)           grant = SRC_WB;
        else if (!fifo_empty) grant = SRC_LU;
    end

    assign pop = (grant == SRC_LU);

    // Stall lands in the cycle after the limit-th wb grant over a waiting FIFO,
    // so the head is guaranteed to be granted while the stall is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            wb_stall <= 1'b0;
            if (grant == SRC_WB && fifo_cnt != '0) begin
                starve_cnt <= starve_cnt + 1'b1;
                wb_stall   <= (starve_cnt == SC_W'(STARVE_LIMIT - 1));
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ru_wr   <= 1'b0;
            ru_rd   <= '0;
            ru_data <= '0;
            out_src <= SRC_NONE;
        end else begin
            ru_wr   <= (grant != SRC_NONE);
            out_src <= grant;
            if (grant == SRC_WB) begin
                ru_rd   <= bus.wbRd;
                ru_data <= bus.wbData;
            end else if (grant == SRC_LU) begin
                ru_rd   <= head.rd;
                ru_data <= head.data;
            end
        end
    end

    // Retire at the edge the register unit captures; a same-edge alloc wins.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ru_wr && out_src == SRC_LU)             pend_clr[ru_rd]       = 1'b1;
        if (bus.allocValid && bus.allocRd != '0)   pend_set[bus.allocRd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            alloc_err <= 1'b0;
        end else begin
            pend      <= (pend & ~pend_clr) | pend_set;
            alloc_err <= alloc_err | (|(pend_set & pend & ~pend_clr));
        end
    end

    assign bus.luReady  = !fifo_full;
    assign bus.wbStall  = wb_stall;
    assign bus.hazRs1   = pend[bus.rs1];
    assign bus.hazRs2   = pend[bus.rs2];
    assign bus.pendMask = pend;
    assign bus.allocErr = alloc_err;
    assign bus.ruWr     = ru_wr;
    assign bus.ruRd     = ru_rd;
    assign bus.ruData   = ru_data;

endmodule

// File: tb/tb_ru_wr_arbiter.sv
// Directed bench for ru_wr_arbiter: vector table plus hand-written sequences for
// back-pressure/starvation, asynchronous reset and scoreboard corner cases.
module tb_ru_wr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ru_wr_arbiter_if #(.DATA_W(32), .NREG(32)) bus ();

    ru_wr_arbiter #(
        .DATA_W       (32),
        .NREG         (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_wr;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        lu_valid;
        logic [4:0]  lu_rd;
        logic [31:0] lu_data;
        logic        al_valid;
        logic [4:0]  al_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        x_ready;
        logic        x_stall;
        logic        x_haz1;
        logic        x_haz2;
        logic        x_wr;
        logic [4:0]  x_rd;
        logic [31:0] x_data;
        logic [31:0] x_pend;
        logic        x_err;
    } vec_t;

    vec_t vecs [13];

    int bp_rd    [10] = '{1, 2, 3, 4, 5, 6, 6, 7, 0, 0};
    int bp_luv   [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int bp_lurd  [10] = '{10, 11, 0, 0, 0, 0, 0, 0, 0, 0};
    int bp_ready [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    int bp_stall [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int bp_xwr   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int bp_xrd   [10] = '{1, 2, 3, 4, 5, 10, 6, 7, 11, 11};
    int bp_xdata [10] = '{'h101, 'h102, 'h103, 'h104, 'h105, 'hA0, 'h106, 'h107, 'hB0, 'hB0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wbWr       = 1'b0;
        bus.wbRd       = '0;
        bus.wbData     = '0;
        bus.luValid    = 1'b0;
        bus.luRd       = '0;
        bus.luData     = '0;
        bus.allocValid = 1'b0;
        bus.allocRd    = '0;
        bus.rs1        = '0;
        bus.rs2        = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.wbWr       = v.wb_wr;
        bus.wbRd       = v.wb_rd;
        bus.wbData     = v.wb_data;
        bus.luValid    = v.lu_valid;
        bus.luRd       = v.lu_rd;
        bus.luData     = v.lu_data;
        bus.allocValid = v.al_valid;
        bus.allocRd    = v.al_rd;
        bus.rs1        = v.rs1;
        bus.rs2        = v.rs2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          wb: wr rd data          lu: v rd data   al: v rd  rs1 rs2 | rdy stl h1 h2 | wr rd data pend err
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,  1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h55,       32'h80, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[9]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55,       32'h0,  1'b0};
        vecs[11] = '{1'b1, 5'd0, 32'hAAAA,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99,       32'h0,  1'b0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       32'h0,  1'b0};

        // Power-on reset state
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_ruWr",     64'(bus.ruWr),     64'(0));
        chk("rst_ruRd",     64'(bus.ruRd),     64'(0));
        chk("rst_ruData",   64'(bus.ruData),   64'(0));
        chk("rst_luReady",  64'(bus.luReady),  64'(1));
        chk("rst_wbStall",  64'(bus.wbStall),  64'(0));
        chk("rst_pendMask", 64'(bus.pendMask), 64'(0));
        chk("rst_allocErr", 64'(bus.allocErr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table: lone writeback, scoreboard lifecycle, zero-register cases
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_luReady", i), 64'(bus.luReady), 64'(vecs[i].x_ready));
            chk($sformatf("v%0d_wbStall", i), 64'(bus.wbStall), 64'(vecs[i].x_stall));
            chk($sformatf("v%0d_hazRs1", i),  64'(bus.hazRs1),  64'(vecs[i].x_haz1));
            chk($sformatf("v%0d_hazRs2", i),  64'(bus.hazRs2),  64'(vecs[i].x_haz2));
            tick();
            chk($sformatf("v%0d_ruWr", i),     64'(bus.ruWr),     64'(vecs[i].x_wr));
            chk($sformatf("v%0d_ruRd", i),     64'(bus.ruRd),     64'(vecs[i].x_rd));
            chk($sformatf("v%0d_ruData", i),   64'(bus.ruData),   64'(vecs[i].x_data));
            chk($sformatf("v%0d_pendMask", i), 64'(bus.pendMask), 64'(vecs[i].x_pend));
            chk($sformatf("v%0d_allocErr", i), 64'(bus.allocErr), 64'(vecs[i].x_err));
        end

        // Back-pressure and starvation: wb every cycle, two lu pushes
        for (int c = 0; c < 10; c++) begin
            idle();
            bus.wbWr    = (bp_rd[c] != 0);
            bus.wbRd    = 5'(bp_rd[c]);
            bus.wbData  = 32'(32'h100 + bp_rd[c]);
            bus.luValid = (bp_luv[c] != 0);
            bus.luRd    = 5'(bp_lurd[c]);
            bus.luData  = (c == 0) ? 32'hA0 : 32'hB0;
            #1;
            chk($sformatf("bp%0d_luReady", c), 64'(bus.luReady), 64'(bp_ready[c]));
            chk($sformatf("bp%0d_wbStall", c), 64'(bus.wbStall), 64'(bp_stall[c]));
            tick();
            chk($sformatf("bp%0d_ruWr", c),   64'(bus.ruWr),   64'(bp_xwr[c]));
            chk($sformatf("bp%0d_ruRd", c),   64'(bus.ruRd),   64'(bp_xrd[c]));
            chk($sformatf("bp%0d_ruData", c), 64'(bus.ruData), 64'(bp_xdata[c]));
        end

        // Reset mid-operation: FIFO full, pendMask 0x30
        idle(); bus.wbWr = 1'b1; bus.wbRd = 5'd1; bus.allocValid = 1'b1; bus.allocRd = 5'd4;
        tick();
        idle(); bus.wbWr = 1'b1; bus.wbRd = 5'd2; bus.allocValid = 1'b1; bus.allocRd = 5'd5;
        bus.luValid = 1'b1; bus.luRd = 5'd4; bus.luData = 32'h44;
        tick();
        idle(); bus.wbWr = 1'b1; bus.wbRd = 5'd3; bus.luValid = 1'b1; bus.luRd = 5'd5; bus.luData = 32'h55;
        tick();
        idle(); bus.wbWr = 1'b1; bus.wbRd = 5'd4; bus.rs1 = 5'd4;
        #1;
        chk("prerst_luReady",  64'(bus.luReady),  64'(0));
        chk("prerst_pendMask", 64'(bus.pendMask), 64'(32'h30));
        chk("prerst_ruWr",     64'(bus.ruWr),     64'(1));
        chk("prerst_hazRs1",   64'(bus.hazRs1),   64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ruWr",     64'(bus.ruWr),     64'(0));
        chk("arst_ruRd",     64'(bus.ruRd),     64'(0));
        chk("arst_ruData",   64'(bus.ruData),   64'(0));
        chk("arst_luReady",  64'(bus.luReady),  64'(1));
        chk("arst_pendMask", 64'(bus.pendMask), 64'(0));
        chk("arst_hazRs1",   64'(bus.hazRs1),   64'(0));
        chk("arst_wbStall",  64'(bus.wbStall),  64'(0));
        idle();
        #2;
        rst_n = 1'b1;
        tick();
        chk("postrst_ruWr0", 64'(bus.ruWr), 64'(0));
        tick();
        chk("postrst_ruWr1", 64'(bus.ruWr), 64'(0));

        // Scoreboard: alloc colliding with retirement, then double alloc
        idle(); bus.allocValid = 1'b1; bus.allocRd = 5'd3;
        tick();
        chk("sb_set3", 64'(bus.pendMask), 64'(32'h8));
        idle(); bus.luValid = 1'b1; bus.luRd = 5'd3; bus.luData = 32'h33;
        tick();
        idle();
        tick();
        chk("sb_ruWr",  64'(bus.ruWr), 64'(1));
        chk("sb_ruRd",  64'(bus.ruRd), 64'(3));
        idle(); bus.allocValid = 1'b1; bus.allocRd = 5'd3;
        tick();
        chk("sb_setwins", 64'(bus.pendMask), 64'(32'h8));
        idle(); bus.allocValid = 1'b1; bus.allocRd = 5'd3;
        tick();
        chk("sb_allocErr", 64'(bus.allocErr), 64'(1));
        chk("sb_pend3",    64'(bus.pendMask), 64'(32'h8));
        idle();
        tick();
        tick();
        chk("sb_allocErr_sticky", 64'(bus.allocErr), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ru_wr_arbiter.md
Name: ru_wr_arbiter

Overview:
- Shares the register unit's single write port between two requesters: main-pipeline writeback (priority) and a long-latency unit (load/divide) whose results queue in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against in-flight long-latency results.
- Sits between writeback/long-latency unit and the register unit. Drives the register unit's ruWr/rd/DataWr from registered outputs.

Parameters:
- DATA_W, 32, register data width
- NREG, 32, number of architectural registers (index width clog2(NREG) = 5)
- FIFO_DEPTH, 2, long-latency result queue entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive wb grants with FIFO non-empty before FIFO is forced

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbWr  in  1  pipeline writeback request
- wbRd  in  5  writeback destination
- wbData  in  DATA_W  writeback data
- wbStall  out  1  pipeline must hold its writeback this cycle
- luValid  in  1  long-latency result valid
- luReady  out  1  FIFO can accept
- luRd  in  5  result destination
- luData  in  DATA_W  result data
- allocValid  in  1  issue of a long-latency op
- allocRd  in  5  its destination
- rs1, rs2  in  5  decode source indices
- hazRs1, hazRs2  out  1  source is pending
- pendMask  out  NREG  scoreboard bits
- allocErr  out  1  sticky: alloc to an already-pending register
- ruWr  out  1  to register unit write enable
- ruRd  out  5  to register unit rd
- ruData  out  DATA_W  to register unit DataWr

Behaviour:
- Reset, asynchronous and active-low: FIFO empty, pendMask=0, starve counter=0, wbStall=0, allocErr=0, ruWr=0, ruRd=0, ruData=0, output-source flag=0.
- FIFO push:
  - luReady = !full (combinational).
  - Push when luValid && luReady.
  - If luRd==0, the handshake completes but nothing is enqueued.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full flag is exact (count register, no lost entry).
- Grant, per cycle:
  - wbReq = wbWr && wbRd!=0 && !wbStall.
  - If wbReq: grant wb.
  - Else if FIFO non-empty: pop head, grant lu.
  - Else: no write.
  - wbWr with wbRd==0 is a non-request.
- Starvation:
  - Counter increments on each wb grant while FIFO is non-empty.
  - Counter clears on any lu grant or when FIFO is empty.
  - On reaching STARVE_LIMIT, wbStall is registered high for exactly one cycle.
  - In that cycle wbWr is ignored and the FIFO head is granted.
  - The pipeline holds its writeback and re-presents it next cycle.
  - Counter then clears.
- Output latency:
  - Grant in cycle T: ruWr/ruRd/ruData valid during T+1 (registered).
  - The register unit captures at edge end of T+1.
  - With no grant, ruWr=0; ruRd/ruData hold.
- Push and pop in the same cycle are both allowed, count unchanged.
- When full, push and pop in the same cycle: luReady=0 this cycle (registered full). No simultaneous push, by definition.
- Scoreboard:
  - Set bit allocRd on allocValid && allocRd!=0.
  - Clear bit ruRd at the edge where ruWr=1 with source=lu, i.e. the same edge the register unit captures the data.
  - Set and clear of the same bit in the same cycle: set wins.
  - Alloc to a bit already 1: bit stays 1, allocErr set (sticky until reset).
  - Bit 0 is never set.
- Hazards: hazRs1 = pendMask[rs1]; hazRs2 = pendMask[rs2]. Both are combinational from the register; rs==0 gives 0.
- Writeback to a pending register is not checked; avoiding WAW against in-flight ops is the issuer's duty.

Decomposition:
- Shared package ru_pkg:
  - REG_IDX_W=5, NREG=32
  - typedef reg_idx_t
  - typedef wr_req_t {rd, data}
  - enum wr_src_e {SRC_NONE, SRC_WB, SRC_LU}
- One sub-module: ru_wr_fifo, a parameterised sync FIFO of wr_req_t with full/empty/count outputs.
- Scoreboard, starve counter and grant logic stay in the top.

Test Plan:
- Reset mid-operation:
  - Stimulus: FIFO holding 2 entries, pendMask=0x0000_0030, drop rst_n asynchronously.
  - Required: outputs immediately 0, luReady=1, pendMask=0.
- Lone writeback:
  - Stimulus: wbWr=1, wbRd=5, wbData=0xDEADBEEF in cycle T, FIFO empty.
  - Required: ruWr=1, ruRd=5, ruData=0xDEADBEEF in T+1; ruWr=0 in T+2.
- Scoreboard lifecycle:
  - Stimulus: allocRd=7; then luValid with luRd=7, luData=0x55 while wbWr idle.
  - Required: pendMask[7]=1 and hazRs1 (rs1=7) high until the edge where ruWr=1/ruRd=7 is captured, then 0.
- Back-pressure:
  - Stimulus: two lu pushes while wbWr=1 with rd=1..n every cycle.
  - Required: luReady=0 after the second push.
  - Required: wb granted for 4 cycles, then wbStall=1 for one cycle and the FIFO head is written.
  - Required: luReady returns to 1 the cycle after the pop.
- Zero-register handling:
  - Stimulus: wbWr=1, wbRd=0 with FIFO head rd=9.
  - Required: FIFO entry written (ruRd=9) next cycle.
  - Stimulus: luRd=0 push.
  - Required: accepted, no write, count unchanged.
- Scoreboard edge cases:
  - Stimulus: allocValid for rd=3 in the same cycle the lu write of rd=3 is captured.
  - Required: pendMask[3] stays 1.
  - Stimulus: a second alloc of rd=3.
  - Required: allocErr=1 and it stays 1.
